// File: rtl/cache_ahb_sl_master.sv
// ---------------------------------------------------------------------------
// cache_ahb_sl_master : flash-side AHB-Lite SINGLE-word read master for the cache
// Rev 1.0 : initial release
// ---------------------------------------------------------------------------
`default_nettype none

module cache_ahb_sl_master #(
  parameter logic [3:0]  HPROT_VAL = 4'b0011,
  parameter logic [31:0] ERR_DATA  = 32'hDEAD_BEEF
) (
  input  logic        i_hclk,
  input  logic        i_hnreset,
  input  logic        i_sl_en,
  input  logic [29:0] i_sl_addr,
  output logic        o_sl_ready,
  output logic [31:0] o_sl_rdata,
  output logic        o_sl_err,
  output logic [31:0] o_m_haddr,
  output logic [1:0]  o_m_htrans,
  output logic        o_m_hwrite,
  output logic [2:0]  o_m_hsize,
  output logic [2:0]  o_m_hburst,
  output logic [3:0]  o_m_hprot,
  input  logic        i_m_hready,
  input  logic        i_m_hresp,
  input  logic [31:0] i_m_hrdata
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADDR = 2'd1,
    S_DATA = 2'd2,
    S_ERR2 = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [29:0] r_addr;
  logic [29:0] r_pend_addr;
  logic        r_pend_vld;
  logic [31:0] r_rdata;

  logic        w_done;
  logic        w_err;
  logic        w_ready;
  logic [31:0] w_rdata;
  logic        w_issue;
  logic [29:0] w_issue_addr;

  always_comb begin
    w_state_nxt = r_state;
    w_done      = 1'b0;
    w_err       = 1'b0;
    w_ready     = 1'b0;
    w_rdata     = r_rdata;
    case (r_state)
      S_IDLE: begin
        w_ready = ~r_pend_vld;
        if (i_sl_en || r_pend_vld) w_state_nxt = S_ADDR;
      end
      S_ADDR: begin
        if (i_m_hready) w_state_nxt = S_DATA;
      end
      S_DATA: begin
        if (i_m_hready) begin
          w_done = 1'b1;
          w_err  = i_m_hresp;
        end else if (i_m_hresp) begin
          w_state_nxt = S_ERR2;
        end
      end
      S_ERR2: begin
        w_done = 1'b1;
        w_err  = 1'b1;
      end
      default: w_state_nxt = S_IDLE;
    endcase
    // Completion passes data straight through so the controller sees it this cycle
    if (w_done) begin
      w_ready     = 1'b1;
      w_rdata     = w_err ? ERR_DATA : i_m_hrdata;
      w_state_nxt = (i_sl_en || r_pend_vld) ? S_ADDR : S_IDLE;
    end
  end

  // A fresh request always beats the pending one: it is the demand miss
  assign w_issue      = ((r_state == S_IDLE) || w_done) && (i_sl_en || r_pend_vld);
  assign w_issue_addr = i_sl_en ? i_sl_addr : r_pend_addr;

  always_ff @(posedge i_hclk or negedge i_hnreset) begin
    if (!i_hnreset) begin
      r_state     <= S_IDLE;
      r_addr      <= 30'd0;
      r_pend_addr <= 30'd0;
      r_pend_vld  <= 1'b0;
      r_rdata     <= 32'd0;
    end else begin
      r_state <= w_state_nxt;
      if (w_issue) begin
        r_addr     <= w_issue_addr;
        r_pend_vld <= 1'b0;
      end else if (i_sl_en) begin
        r_pend_addr <= i_sl_addr;
        r_pend_vld  <= 1'b1;
      end
      if (w_done) r_rdata <= w_rdata;
    end
  end

  assign o_sl_ready = w_ready;
  assign o_sl_rdata = w_rdata;
  assign o_sl_err   = w_err;
  assign o_m_haddr  = {r_addr, 2'b00};
  assign o_m_htrans = (r_state == S_ADDR) ? 2'b10 : 2'b00;
  assign o_m_hwrite = 1'b0;
  assign o_m_hsize  = 3'b010;
  assign o_m_hburst = 3'b000;
  assign o_m_hprot  = HPROT_VAL;

endmodule

`default_nettype wire
